arbiter0: RTL and testbench

ARBITER0 -- requirements
Module: arbiter0

---
 rtl/arbiter0_if.sv | 24 ++
 rtl/arbiter0.sv | 100 ++++++++++
 tb/tb_arbiter0.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/arbiter0_if.sv
// Handshake bundle between two input ports and one output-port arbiter.
// The slave side is the arbiter; the master side drives requests and ready.
interface arbiter0_if;
    logic req0;
    logic req1;
    logic tail0;
    logic tail1;
    logic out_ready;
    logic g00;
    logic g01;
    logic busy;
    logic xfer;
    logic err_timeout;

    modport slave (
        input  req0, req1, tail0, tail1, out_ready,
        output g00, g01, busy, xfer, err_timeout
    );

    modport master (
        output req0, req1, tail0, tail1, out_ready,
        input  g00, g01, busy, xfer, err_timeout
    );
endinterface

// File: rtl/arbiter0.sv
// Two-requester packet arbiter: round-robin on release, grant held for a
// whole packet, forced release after MAX_PKT_LEN flits without a tail.
module arbiter0 #(
    parameter int MAX_PKT_LEN = 16,
    parameter bit PRIO_INIT   = 1'b0
) (
    input logic        clk,
    input logic        rst,
    arbiter0_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [7:0] LIMIT = 8'(MAX_PKT_LEN - 1);

    state_t     r_state;
    state_t     w_state_n;
    logic       r_prio;
    logic       w_prio_n;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_n;
    logic       r_err;
    logic       w_err_n;
    logic       w_req_g;
    logic       w_tail_g;
    logic       w_fire;
    logic       w_release;
    logic       w_timeout;
    logic       w_other;

    assign w_req_g  = (r_state == GNT0) ? bus.req0  : bus.req1;
    assign w_tail_g = (r_state == GNT0) ? bus.tail0 : bus.tail1;
    assign w_other  = (r_state == GNT0);
    assign w_fire   = (((r_state == GNT0) & bus.req0) |
                       ((r_state == GNT1) & bus.req1)) & bus.out_ready;

    always_comb begin
        w_state_n = r_state;
        w_prio_n  = r_prio;
        w_cnt_n   = r_cnt;
        w_err_n   = 1'b0;
        w_release = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_n = 8'd0;
                if (bus.req0 && bus.req1)
                    w_state_n = r_prio ? GNT1 : GNT0;
                else if (bus.req0)
                    w_state_n = GNT0;
                else if (bus.req1)
                    w_state_n = GNT1;
            end
            GNT0, GNT1: begin
                if (!w_req_g) begin
                    w_release = 1'b1;
                end else if (w_fire && w_tail_g) begin
                    w_release = 1'b1;
                end else if (w_fire) begin
                    if (r_cnt >= LIMIT) begin
                        w_release = 1'b1;
                        w_timeout = 1'b1;
                    end else begin
                        w_cnt_n = r_cnt + 8'd1;
                    end
                end
                // Hand over to the other port directly when it is waiting
                if (w_release) begin
                    w_prio_n = w_other;
                    w_cnt_n  = 8'd0;
                    w_err_n  = w_timeout;
                    if (w_other)
                        w_state_n = bus.req1 ? GNT1 : IDLE;
                    else
                        w_state_n = bus.req0 ? GNT0 : IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= PRIO_INIT;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_prio  <= w_prio_n;
            r_cnt   <= w_cnt_n;
            r_err   <= w_err_n;
        end
    end

    assign bus.g00         = (r_state == GNT0);
    assign bus.g01         = (r_state == GNT1);
    assign bus.busy        = (r_state != IDLE);
    assign bus.xfer        = w_fire;
    assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_arbiter0.sv
// Bench for arbiter0: directed vector table, hand sequences for timeout
// and async reset, then random traffic against a packet-level model.
module tb_arbiter0;
    localparam int MAXL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    arbiter0_if bus ();

    arbiter0 #(.MAX_PKT_LEN(MAXL), .PRIO_INIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: owner of the output (-1 none), tie-break pointer,
    // flits forwarded in the current packet, pending timeout flag.
    int m_own;
    int m_prio;
    int m_cnt;
    bit m_err;
    bit r [2];
    bit t [2];
    bit rdy;

    typedef struct {
        bit r0, r1, t0, t1, rd;
        bit xf, g0, g1, er;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r0, bit r1, bit t0, bit t1, bit rd,
                                bit xf, bit g0, bit g1, bit er);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.t0 = t0; v.t1 = t1; v.rd = rd;
        v.xf = xf; v.g0 = g0; v.g1 = g1; v.er = er;
        return v;
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_prio = 0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    function automatic bit m_xfer();
        return (m_own >= 0) && r[m_own] && rdy;
    endfunction

    task automatic model_edge();
        int g;
        bit rel;
        bit to;
        rel = 1'b0;
        to  = 1'b0;
        if (m_own < 0) begin
            m_cnt = 0;
            if (r[0] && r[1]) m_own = m_prio;
            else if (r[0])    m_own = 0;
            else if (r[1])    m_own = 1;
        end else begin
            g = m_own;
            if (!r[g]) rel = 1'b1;
            else if (rdy && t[g]) rel = 1'b1;
            else if (rdy) begin
                if (m_cnt + 1 >= MAXL) begin
                    rel = 1'b1;
                    to  = 1'b1;
                end else m_cnt++;
            end
            if (rel) begin
                m_prio = 1 - g;
                m_own  = r[1 - g] ? 1 - g : -1;
                m_cnt  = 0;
            end
        end
        m_err = to;
    endtask

    task automatic drive(bit r0, bit r1, bit t0, bit t1, bit rd);
        r[0] = r0; r[1] = r1; t[0] = t0; t[1] = t1; rdy = rd;
        bus.req0 = r0; bus.req1 = r1;
        bus.tail0 = t0; bus.tail1 = t1;
        bus.out_ready = rd;
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic cycle();
        #3;
        chk("xfer", int'(bus.xfer), int'(m_xfer()));
        @(posedge clk);
        model_edge();
        #1;
        chk("g00", int'(bus.g00), int'(m_own == 0));
        chk("g01", int'(bus.g01), int'(m_own == 1));
        chk("busy", int'(bus.busy), int'(m_own >= 0));
        chk("err", int'(bus.err_timeout), int'(m_err));
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        model_reset();
        // handover, alternation, stalled ready, abort
        tbl[0]  = mk(1,1,0,0,1, 0,1,0,0);
        tbl[1]  = mk(1,1,0,0,1, 1,1,0,0);
        tbl[2]  = mk(1,1,0,0,1, 1,1,0,0);
        tbl[3]  = mk(1,1,1,0,1, 1,0,1,0);
        tbl[4]  = mk(1,1,1,1,1, 1,1,0,0);
        tbl[5]  = mk(1,1,1,1,1, 1,0,1,0);
        tbl[6]  = mk(1,1,1,1,1, 1,1,0,0);
        tbl[7]  = mk(1,1,1,1,1, 1,0,1,0);
        tbl[8]  = mk(0,0,0,0,1, 0,0,0,0);
        tbl[9]  = mk(1,0,0,0,0, 0,1,0,0);
        tbl[10] = mk(1,0,1,0,0, 0,1,0,0);
        tbl[11] = mk(1,0,1,0,0, 0,1,0,0);
        tbl[12] = mk(1,1,1,1,0, 0,1,0,0);
        tbl[13] = mk(1,0,1,0,0, 0,1,0,0);
        tbl[14] = mk(1,0,1,0,0, 0,1,0,0);
        tbl[15] = mk(1,0,1,0,1, 1,0,0,0);
        tbl[16] = mk(0,1,0,0,1, 0,0,1,0);
        tbl[17] = mk(0,1,0,0,1, 1,0,1,0);
        tbl[18] = mk(1,0,0,0,1, 0,1,0,0);
        tbl[19] = mk(1,0,1,0,1, 1,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_g00", int'(bus.g00), 0);
        chk("rst_g01", int'(bus.g01), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_xfer", int'(bus.xfer), 0);
        chk("rst_err", int'(bus.err_timeout), 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].t0, tbl[i].t1, tbl[i].rd);
            #3;
            chk($sformatf("tbl%0d_xfer", i), int'(bus.xfer), int'(tbl[i].xf));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("tbl%0d_g00", i), int'(bus.g00), int'(tbl[i].g0));
            chk($sformatf("tbl%0d_g01", i), int'(bus.g01), int'(tbl[i].g1));
            chk($sformatf("tbl%0d_err", i), int'(bus.err_timeout), int'(tbl[i].er));
        end

        // timeout: MAXL flits without a tail force release
        drive(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle();
        chk("to_g00", int'(bus.g00), 0);
        chk("to_err", int'(bus.err_timeout), 1);
        drive(1, 1, 0, 0, 1);
        cycle();
        chk("to_prio_g01", int'(bus.g01), 1);
        chk("to_err_clr", int'(bus.err_timeout), 0);
        drive(0, 0, 0, 0, 1);
        cycle();

        // asynchronous reset mid-packet
        drive(1, 0, 0, 0, 0);
        cycle();
        chk("ar_pre_g00", int'(bus.g00), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("ar_g00", int'(bus.g00), 0);
        chk("ar_busy", int'(bus.busy), 0);
        chk("ar_xfer", int'(bus.xfer), 0);
        chk("ar_err", int'(bus.err_timeout), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1, 0, 0, 1);
        cycle();
        chk("ar_g01", int'(bus.g01), 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom % 8) != 0, ($urandom % 8) != 0,
                  ($urandom % 6) == 0, ($urandom % 6) == 0,
                  ($urandom % 4) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
